// File: rtl/mem_request_unit.sv
// Multi-state fetch/execute/memory sequencer: turns decoded memory/halt controls into
// cache request strobes, waits on iHit/dHit, and gates PC advance and IR load.
module mem_request_unit #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             dMemRe,
   input  logic             dMemWr,
   input  logic             Halt,
   input  logic             iHit,
   input  logic             dHit,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             irEN,
   output logic             pcEN,
   output logic             halt_out,
   output logic             busy,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_HALTED
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state;
   state_t           w_next;
   logic             r_re;
   logic             r_we;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_cnt_inc;
   logic             w_latch;
   logic             w_clr;

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Latched data-access flags; write wins when both are decoded
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_re <= 1'b0;
         r_we <= 1'b0;
      end else if (w_latch) begin
         r_we <= dMemWr;
         r_re <= dMemRe & ~dMemWr;
      end else if (w_clr) begin
         r_re <= 1'b0;
         r_we <= 1'b0;
      end
   end

   // Saturating wait-cycle counter
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_stall_cnt <= '0;
      end else if (w_cnt_inc && (r_stall_cnt != CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;

   // Next-state and Moore outputs; irEN/pcEN also qualify on the hit inputs
   always_comb begin
      w_next    = r_state;
      w_cnt_inc = 1'b0;
      w_latch   = 1'b0;
      w_clr     = 1'b0;
      imemREN   = 1'b0;
      dmemREN   = 1'b0;
      dmemWEN   = 1'b0;
      irEN      = 1'b0;
      pcEN      = 1'b0;
      halt_out  = 1'b0;
      busy      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_next = S_FETCH;
         end
         S_FETCH: begin
            imemREN = 1'b1;
            if (iHit) begin
               irEN   = 1'b1;
               w_next = S_EXEC;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_EXEC: begin
            if (Halt) begin
               w_next = S_HALTED;
            end else if (dMemWr || dMemRe) begin
               w_latch = 1'b1;
               w_next  = S_MEM;
            end else begin
               pcEN   = 1'b1;
               w_next = S_FETCH;
            end
         end
         S_MEM: begin
            dmemWEN = r_we;
            dmemREN = r_re;
            busy    = 1'b1;
            if (dHit) begin
               pcEN   = 1'b1;
               w_clr  = 1'b1;
               w_next = S_FETCH;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_HALTED: begin
            halt_out = 1'b1;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
Sequencer on the consuming end of the decoded control signals (dMemRe, dMemWr, Halt). It converts them into cache request strobes and handles the iHit/dHit handshakes. It gates PC advance and instruction-register load, so the single-cycle datapath becomes a stall-safe multi-state fetch/execute/memory flow. It sits between the control unit and the cache/memory-control interface, alongside the PC and instruction register.

Parameters:
CNT_W, 16, width of saturating stall-cycle counter

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
dMemRe  in  1  decoder: current instruction reads data memory
dMemWr  in  1  decoder: current instruction writes data memory
Halt  in  1  decoder: current instruction is HALT
iHit  in  1  instruction cache: fetch complete this cycle
dHit  in  1  data cache: load/store complete this cycle
imemREN  out  1  instruction fetch request
dmemREN  out  1  data read request
dmemWEN  out  1  data write request
irEN  out  1  load instruction register (one-cycle pulse)
pcEN  out  1  advance PC (one-cycle pulse)
halt_out  out  1  processor halted, sticky
busy  out  1  data access outstanding
stall_cnt  out  CNT_W  cycles spent waiting on iHit/dHit

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: nRST low forces state IDLE, clears the latched re/we flags and zeroes stall_cnt immediately, without waiting for a clock edge.
- Outputs are Moore, decoded from state and latched flags. irEN and pcEN additionally qualify on the hit inputs.
- During reset and in IDLE, every output is 0.
- States: IDLE, FETCH, EXEC, MEM, HALTED.
- IDLE: all outputs 0. Goes to FETCH on the first edge after reset release.
- FETCH: imemREN=1.
  - iHit=1 -> irEN=1 this cycle; next state EXEC.
  - iHit=0 -> stay; stall_cnt+1.
  - dHit is ignored in FETCH.
- EXEC: one cycle, decoder inputs valid; no requests asserted.
  - Halt=1 -> HALTED. Halt has priority over memory flags; pcEN=0.
  - else dMemWr or dMemRe -> latch we=dMemWr and re=dMemRe & ~dMemWr (write wins if both set); next state MEM.
  - else pcEN=1; next state FETCH.
- MEM: dmemWEN=we, dmemREN=re, busy=1. Request held stable until the handshake completes.
  - dHit=1 -> pcEN=1; clear latched flags; next state FETCH.
  - dHit=0 -> stay; stall_cnt+1.
  - iHit is ignored in MEM.
- HALTED: halt_out=1; every other output 0. Only nRST leaves this state.
- Instruction latency: non-memory instruction = fetch cycles + 1. Load/store = fetch cycles + 1 + data cycles.
- Hit arriving in the same cycle the request is first asserted completes that cycle (zero-wait).
- stall_cnt: increments once per waiting cycle, saturates at 2^CNT_W-1 with no wrap, holds in HALTED.
- Reset mid-MEM: dmemREN/dmemWEN drop asynchronously. No pcEN pulse is produced. Restart is from IDLE.
- pcEN and irEN are never asserted in the same cycle. At most one of imemREN/dmemREN/dmemWEN is high in any cycle.

Test Plan:
- Reset, then ALU op with iHit on the 3rd FETCH cycle -> sequence IDLE,FETCH×3,EXEC; irEN pulse on cycle 3; pcEN pulse in EXEC; stall_cnt=2.
- LW with dMemRe=1, dHit after 4 MEM cycles -> dmemREN high 4 cycles, busy=1, pcEN only on the dHit cycle, dmemWEN never high.
- dMemRe=1 and dMemWr=1 together in EXEC -> MEM asserts dmemWEN=1 and dmemREN=0.
- Halt=1 with dMemWr=1 in EXEC -> HALTED, halt_out=1, no data request ever issued; further iHit/dHit pulses produce no change.
- nRST pulled low mid-MEM (asynchronously, between edges) -> all outputs 0 before the next edge; after release, IDLE then FETCH.
- CNT_W=4 with 20 cycles of no iHit -> stall_cnt saturates at 15.
